// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, instruction field layout and widths.
// Imported by both the ALU and its issue controller so the encodings cannot drift apart.
package alu_pkg;

    localparam int DATA_W  = 4;
    localparam int NREG    = 4;
    localparam int REG_W   = 2;
    localparam int INSTR_W = 10;

    localparam int OP_MSB  = 9;
    localparam int OP_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 4;
    localparam int RS1_MSB = 3;
    localparam int RS1_LSB = 2;
    localparam int RS2_MSB = 1;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef logic [3:0] op_t;

    localparam op_t OP_ADD = 4'd0;
    localparam op_t OP_SUB = 4'd1;
    localparam op_t OP_AND = 4'd2;
    localparam op_t OP_OR  = 4'd3;
    localparam op_t OP_XOR = 4'd4;
    localparam op_t OP_EQ  = 4'd5;
    localparam op_t OP_GT  = 4'd6;
    localparam op_t OP_LT  = 4'd7;
    localparam op_t OP_SHR = 4'd8;
    localparam op_t OP_SHL = 4'd9;
    localparam op_t OP_LDI = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Opcodes 10..14 have no ALU meaning and must never write the register file.
    function automatic logic isIllegalOp(input op_t op);
        return (op >= 4'd10) && (op <= 4'd14);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_alu.sv
// Existing 4-bit combinational ALU; sel is the raw opcode, comparisons are unsigned.
module ALU
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  op_t               sel_i,
    output logic [DATA_W-1:0] y_o
);

    // Shifts use the whole 4-bit amount, so amounts of 4 or more shift everything out.
    always_comb begin
        y_o = '0;
        case (sel_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_EQ:   y_o = {{(DATA_W-1){1'b0}}, (a_i == b_i)};
            OP_GT:   y_o = {{(DATA_W-1){1'b0}}, (a_i > b_i)};
            OP_LT:   y_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
            OP_SHR:  y_o = a_i >> b_i;
            OP_SHL:  y_o = a_i << b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 4-bit ALU: accepts instructions, reads a 4x4 register file,
// drives the ALU, writes the result back and publishes it on a valid/ready stream.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [REG_W-1:0]   out_rd,
    output logic               out_err
);

    state_t             state_q;
    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  regFile_q [NREG];
    logic [DATA_W-1:0]  outData_q;
    logic [REG_W-1:0]   outRd_q;
    logic               outErr_q;

    op_t               op;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [DATA_W-1:0] aluA;
    logic [DATA_W-1:0] aluB;
    logic [DATA_W-1:0] aluY;
    logic [DATA_W-1:0] wbData_d;
    logic              illegal;

    assign op      = instr_q[OP_MSB:OP_LSB];
    assign rd      = instr_q[RD_MSB:RD_LSB];
    assign rs1     = instr_q[RS1_MSB:RS1_LSB];
    assign rs2     = instr_q[RS2_MSB:RS2_LSB];
    assign illegal = isIllegalOp(op);
    assign aluA    = regFile_q[rs1];
    assign aluB    = regFile_q[rs2];

    ALU uAlu (
        .a_i   (aluA),
        .b_i   (aluB),
        .sel_i (op),
        .y_o   (aluY)
    );

    always_comb begin
        wbData_d = aluY;
        if (op == OP_LDI) begin
            wbData_d = instr_q[IMM_MSB:IMM_LSB];
        end else if (illegal) begin
            wbData_d = '0;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == RESP);
    assign out_data  = outData_q;
    assign out_rd    = outRd_q;
    assign out_err   = outErr_q;

    // Operands are read before the write edge, so rd aliasing rs1/rs2 sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            outData_q <= '0;
            outRd_q   <= '0;
            outErr_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regFile_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        instr_q <= in_instr;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (!illegal) begin
                        regFile_q[rd] <= wbData_d;
                    end
                    outData_q <= wbData_d;
                    outRd_q   <= rd;
                    outErr_q  <= illegal;
                    state_q   <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
